noc_flit_eject_rx: RTL

// - Receive end of the router link (data/dest/is_tail/send, credit return): sits on a router output port, e.g. the local ejection port.
// - Buffers incoming flits and returns one credit per flit drained.
// - Reassembles SERIALIZATION_FACTOR flits into one AXI-Stream beat.
// - Single-clock (clk_noc) counterpart of the injection-side serializer; no clock crossing.

---
 rtl/noc_flit_eject_rx.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/noc_flit_eject_rx.sv
// noc_flit_eject_rx: receive end of a credit-based router link.
// Buffers flits in a small FIFO, returns one credit per drained flit and reassembles
// SERIALIZATION_FACTOR flits (LSB slice first) into one AXI-Stream beat.
// Optional statistics counters are enabled by defining NOC_EJECT_STATS_EN.
module noc_flit_eject_rx #(
    parameter int unsigned TDATA_WIDTH          = 128,
    parameter int unsigned SERIALIZATION_FACTOR = 1,
    parameter int unsigned DEST_WIDTH           = 6,
    parameter int unsigned TID_WIDTH            = 2,
    parameter int unsigned FLIT_BUFFER_DEPTH    = 2
) (
    input  logic                                    clk_noc,
    input  logic                                    rst_noc_sync,
    input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0] data_in,
    input  logic [DEST_WIDTH-1:0]                   dest_in,
    input  logic                                    is_tail_in,
    input  logic                                    send_in,
    output logic                                    credit_out,
    output logic                                    axis_out_tvalid,
    input  logic                                    axis_out_tready,
    output logic [TDATA_WIDTH-1:0]                  axis_out_tdata,
    output logic                                    axis_out_tlast,
    output logic [TID_WIDTH-1:0]                    axis_out_tid,
    output logic [DEST_WIDTH-TID_WIDTH-1:0]         axis_out_tdest,
    output logic                                    overflow_err,
    output logic [31:0]                             stat_flits,
    output logic [31:0]                             stat_pkts
);

    localparam int unsigned FlitWidth = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int unsigned TdestWidth = DEST_WIDTH - TID_WIDTH;
    localparam int unsigned EntryWidth = FlitWidth + DEST_WIDTH + 1;
    localparam int unsigned PtrWidth = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
    localparam int unsigned CntWidth = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int unsigned IdxWidth =
        (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(FLIT_BUFFER_DEPTH - 1);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(FLIT_BUFFER_DEPTH);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(SERIALIZATION_FACTOR - 1);

    // Flit FIFO storage and control
    logic [EntryWidth-1:0] mem_q [FLIT_BUFFER_DEPTH];
    logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]   count_q, count_d;
    logic                  full, empty, push, pop, drop;
    logic [EntryWidth-1:0] head;
    logic [FlitWidth-1:0]  head_data;
    logic [DEST_WIDTH-1:0] head_dest;
    logic                  head_tail;

    // Beat assembly / output registers
    logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [TID_WIDTH-1:0]   tid_q, tid_d;
    logic [TdestWidth-1:0]  tdest_q, tdest_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;
    logic [IdxWidth-1:0]    idx_q, idx_d;
    logic                   credit_q, overflow_q;

    assign full  = (count_q == DepthCnt);
    assign empty = (count_q == '0);
    // A held beat blocks draining; an accepted beat frees the register in the same cycle.
    assign pop   = !empty && (!tvalid_q || axis_out_tready);
    // A full FIFO still accepts when a pop frees a slot in the same cycle.
    assign push  = send_in && (!full || pop);
    assign drop  = send_in && full && !pop;

    assign head      = mem_q[rd_ptr_q];
    assign head_data = head[EntryWidth-1 -: FlitWidth];
    assign head_dest = head[DEST_WIDTH:1];
    assign head_tail = head[0];

    // FIFO occupancy next state
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntWidth'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntWidth'(1);
        end
    end

    // FIFO pointers, occupancy, credit pulse and sticky overflow flag
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            credit_q <= pop;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO payload storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk_noc) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {data_in, dest_in, is_tail_in};
        end
    end

    // Place the popped flit into its slice; close the beat on the last slice or a tail
    always_comb begin
        tdata_d  = tdata_q;
        tid_d    = tid_q;
        tdest_d  = tdest_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        idx_d    = idx_q;
        if (tvalid_q && axis_out_tready) begin
            tvalid_d = 1'b0;
        end
        if (pop) begin
            if (idx_q == '0) begin
                // First flit: clear stale slices so an early tail leaves zeros above it.
                tdata_d = '0;
                tid_d   = head_dest[DEST_WIDTH-1 -: TID_WIDTH];
                tdest_d = head_dest[TdestWidth-1:0];
            end
            for (int unsigned s = 0; s < SERIALIZATION_FACTOR; s++) begin
                if (IdxWidth'(s) == idx_q) begin
                    tdata_d[s*FlitWidth +: FlitWidth] = head_data;
                end
            end
            if (idx_q == LastIdx || head_tail) begin
                tvalid_d = 1'b1;
                tlast_d  = head_tail;
                idx_d    = '0;
            end else begin
                idx_d = idx_q + IdxWidth'(1);
            end
        end
    end

    // Assembly and output beat registers
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            tdata_q  <= '0;
            tid_q    <= '0;
            tdest_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            tdata_q  <= tdata_d;
            tid_q    <= tid_d;
            tdest_q  <= tdest_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
            idx_q    <= idx_d;
        end
    end

    assign credit_out      = credit_q;
    assign overflow_err    = overflow_q;
    assign axis_out_tvalid = tvalid_q;
    assign axis_out_tdata  = tdata_q;
    assign axis_out_tlast  = tlast_q;
    assign axis_out_tid    = tid_q;
    assign axis_out_tdest  = tdest_q;

`ifdef NOC_EJECT_STATS_EN
    logic [31:0] stat_flits_q, stat_pkts_q;

    // Accepted-flit and delivered-packet counters, wrapping modulo 2^32
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            stat_flits_q <= '0;
            stat_pkts_q  <= '0;
        end else begin
            if (push) begin
                stat_flits_q <= stat_flits_q + 32'd1;
            end
            if (tvalid_q && axis_out_tready && tlast_q) begin
                stat_pkts_q <= stat_pkts_q + 32'd1;
            end
        end
    end

    assign stat_flits = stat_flits_q;
    assign stat_pkts  = stat_pkts_q;
`else
    assign stat_flits = '0;
    assign stat_pkts  = '0;
`endif

endmodule
